// File: rtl/stream_conv3x3.sv
// Streaming 3x3 convolution over a raster image, valid-region only, two-stage multiply/sum pipeline
// with skid-free backpressure; define CONV_SATURATE_EN to clamp the result instead of wrapping it.
module stream_conv3x3 #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 4,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     in_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         out_data,
    output logic                     out_sof,
    output logic                     out_eol,
    input  logic                     coef_we,
    input  logic [3:0]               coef_idx,
    input  logic signed [COEF_W-1:0] coef_data
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int PW = PIX_W + COEF_W + 1;
    localparam int SW = PIX_W + COEF_W + 5;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam int COEF_RST [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    logic [XW-1:0]            x_q, x_d, x_eff;
    logic [YW-1:0]            y_q, y_d, y_eff;
    logic signed [COEF_W-1:0] coef_q [9];
    logic [PIX_W-1:0]         lb0_q [IMG_W];
    logic [PIX_W-1:0]         lb1_q [IMG_W];
    logic [PIX_W-1:0]         win_q [3][2];
    logic [PIX_W-1:0]         col   [3];
    logic [PIX_W-1:0]         tap   [9];
    logic signed [PW-1:0]     prod_d [9];
    logic signed [PW-1:0]     prod_q [9];
    logic                     s1_vld_q, s1_vld_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;
    logic                     out_valid_q, out_sof_q, out_eol_q;
    logic [PIX_W-1:0]         out_data_q;
    logic signed [SW-1:0]     sum_c;
    logic [PIX_W-1:0]         res_c;
    logic                     accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

    // A start-of-frame pixel overrides whatever position the counters hold.
    assign x_eff = in_sof ? '0 : x_q;
    assign y_eff = in_sof ? '0 : y_q;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        s1_vld_d = s1_vld_q;
        s1_sof_d = s1_sof_q;
        s1_eol_d = s1_eol_q;
        if (in_ready) begin
            s1_vld_d = 1'b0;
            s1_sof_d = 1'b0;
            s1_eol_d = 1'b0;
        end
        if (accept) begin
            x_d = (x_eff == X_LAST) ? '0 : x_eff + XW'(1);
            if (x_eff == X_LAST)
                y_d = (y_eff == Y_LAST) ? '0 : y_eff + YW'(1);
            else
                y_d = y_eff;
            s1_vld_d = (x_eff >= XW'(2)) && (y_eff >= YW'(2));
            s1_sof_d = (x_eff == XW'(2)) && (y_eff == YW'(2));
            s1_eol_d = (x_eff == X_LAST);
        end
    end

    // New column: top is two lines back, bottom is the pixel arriving now.
    always_comb begin
        col[0] = lb1_q[x_eff];
        col[1] = lb0_q[x_eff];
        col[2] = in_data;
        for (int r = 0; r < 3; r++) begin
            tap[r*3+0] = win_q[r][0];
            tap[r*3+1] = win_q[r][1];
            tap[r*3+2] = col[r];
        end
        for (int i = 0; i < 9; i++)
            prod_d[i] = PW'($signed({1'b0, tap[i]})) * PW'(coef_q[i]);
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++)
            sum_c = sum_c + SW'(prod_q[i]);
    end

`ifdef CONV_SATURATE_EN
    logic signed [SW-1:0] shifted_c;
    always_comb begin
        shifted_c = sum_c >>> SHIFT;
        if (shifted_c[SW-1])
            res_c = '0;
        else if (|shifted_c[SW-2:PIX_W])
            res_c = '1;
        else
            res_c = shifted_c[PIX_W-1:0];
    end
`else
    always_comb begin
        res_c = PIX_W'(sum_c >>> SHIFT);
    end
`endif

    // Line storage carries no reset; outputs never read it before two lines are written.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[x_eff] <= lb0_q[x_eff];
            lb0_q[x_eff] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            s1_vld_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                coef_q[i] <= COEF_W'(COEF_RST[i]);
                prod_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            s1_vld_q <= s1_vld_d;
            s1_sof_q <= s1_sof_d;
            s1_eol_q <= s1_eol_d;
            if (coef_we && coef_idx < 4'd9)
                coef_q[coef_idx] <= coef_data;
            if (accept) begin
                for (int i = 0; i < 9; i++)
                    prod_q[i] <= prod_d[i];
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= col[r];
                end
            end
            if (in_ready) begin
                out_valid_q <= s1_vld_q;
                out_sof_q   <= s1_sof_q;
                out_eol_q   <= s1_eol_q;
                if (s1_vld_q)
                    out_data_q <= res_c;
            end
        end
    end

endmodule

// File: doc/stream_conv3x3.md
STREAM_CONV3X3 -- requirements
Module: stream_conv3x3

Interface
REQ-001 IMG_W, default 256: pixels per line, range 4 to 4096.
REQ-002 IMG_H, default 256: lines per frame, range 3 to 4096.
REQ-003 PIX_W, default 8: unsigned pixel width.
REQ-004 COEF_W, default 4: signed two's-complement coefficient width.
REQ-005 SHIFT, default 4: arithmetic right shift applied to the sum.
REQ-006 clk  input  1: single clock; all logic is on the rising edge.
REQ-007 rst  input  1: asynchronous, active-high reset.
REQ-008 in_valid  input  1: in_data is valid.
REQ-009 in_ready  output  1: the block can accept a pixel.
REQ-010 in_data  input  PIX_W: raster-order input pixel.
REQ-011 in_sof  input  1: the accepted pixel is pixel (0,0) of a frame.
REQ-012 out_valid  output  1: out_data is valid.
REQ-013 out_ready  input  1: the downstream block accepts the output.
REQ-014 out_data  output  PIX_W: filtered pixel.
REQ-015 out_sof / out_eol  output  1 each: flag the first output of a frame / the last output of a line.
REQ-016 coef_we  input  1: coefficient write strobe.
REQ-017 coef_idx  input  4: kernel tap, row-major 0..8; values 9..15 are ignored.
REQ-018 coef_data  input  COEF_W: coefficient value.

Function
REQ-019 Acceptance: a pixel is accepted when in_valid and in_ready are both high; in_ready = !out_valid || out_ready (combinational).
REQ-020 Stall: when in_ready is low, every pipeline stage, line buffer and counter holds its value.
REQ-021 Counters: x and y advance on each accepted pixel; x wraps at IMG_W-1, and y increments on x wrap and wraps at IMG_H-1.
REQ-022 in_sof resync: an accepted pixel with in_sof=1 is treated as (0,0) regardless of the counters; in_sof has no effect on output data already in the pipeline.
REQ-023 Line buffers: two buffers of IMG_W x PIX_W hold the previous two lines, and a 3x3 window register shifts one column per accepted pixel.
REQ-024 Output region: valid-only, with no border padding; an output is produced for each accepted pixel with x>=2 and y>=2, centred at (x-1,y-1); there are (IMG_W-2)*(IMG_H-2) outputs per frame.
REQ-025 Latency: an output is presented exactly 2 advancing cycles after the pixel that completes its window is accepted.
REQ-026 Pipeline stage 1 registers the nine products pixel*coef, with the pixel zero-extended and the product signed.
REQ-027 Pipeline stage 2 registers the sum, the shift and the range reduction into out_data.
REQ-028 Sum width: PIX_W+COEF_W+5 bits, signed; no intermediate overflow is permitted.
REQ-029 Shift: arithmetic right shift by SHIFT, rounding toward negative infinity.
REQ-030 out_sof is asserted with the output centred at (1,1); out_eol is asserted with outputs centred at x=IMG_W-2.
REQ-031 Coefficient writes are accepted in any cycle, including during a stall.
REQ-032 A written coefficient is used by the stage-1 products in the next cycle after the write; there is no frame shadowing.
REQ-033 out_data, out_sof and out_eol hold stable while out_valid=1 and out_ready=0.

Reset
REQ-034 On reset, out_valid=0, out_data=0, out_sof=0 and out_eol=0; in_ready is then 1.
REQ-035 On reset, x and y are set to 0 and all pipeline valid flags are cleared.
REQ-036 On reset, the coefficients load 1,2,1 / 2,4,2 / 1,2,1 (Gaussian, sum 16).
REQ-037 Line buffer contents are not reset; no output may depend on them before two lines have been written.
REQ-038 Reset asserted mid-frame discards in-flight outputs; the next accepted pixel is treated as (0,0).

Configuration
REQ-039 With CONV_SATURATE_EN defined, the shifted sum is clamped to the range 0..2^PIX_W-1.
REQ-040 Without CONV_SATURATE_EN, out_data is the low PIX_W bits of the shifted sum (wrap-around).

Verification
Benches use IMG_W=8, IMG_H=6 and the defaults otherwise.
REQ-041 Constant frame of 100, default kernel, out_ready=1 -> 24 outputs, all equal to 100; out_sof on the first output; out_eol on every 6th output.
REQ-042 Ramp frame, out_ready toggling 1,0,0,1 -> output sequence identical to the out_ready=1 run; data stable during stalls.
REQ-043 All nine coefficients = 7, pixels = 255 -> sum 16065, shifted 1004 -> 255 with CONV_SATURATE_EN, 236 without.
REQ-044 Centre coefficient 7, other eight coefficients = -1, pixels = 50 -> sum -50, shifted -4 -> 0 with CONV_SATURATE_EN, 252 without.
REQ-045 in_sof pulsed on pixel (3,4) mid-frame -> counters restart; the next out_sof follows 2 lines + 3 pixels later.
REQ-046 rst pulsed mid-frame, then a full frame -> out_valid=0 immediately; exactly 24 correct outputs follow.
